// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants for the fetch/decode boundary
// Purpose : default datapath widths, the NOP encoding presented on empty
//           slots, and a power-of-two helper for elaboration-time checks.
// Ports   : none (package).
package cpu_pkg;

   localparam int DEF_PC_W   = 32;
   localparam int DEF_INST_W = 32;

   // All-zero word is what decode treats as a bubble.
   localparam logic [31:0] NOP_INST = 32'b0;

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/fq_ptr_ctrl.sv
// rtl/fq_ptr_ctrl.sv - pointer/count state and priority chain of the fetch queue
// Purpose : holds write pointer, read pointer and occupancy; resolves
//           reset > stall > flush > push/pop each edge.
// Ports   : i_clk, i_rst            clock, synchronous active-high reset
//           i_start, i_stall,       run enable, global freeze,
//           i_flush                 branch flush
//           i_push, i_pop           requests from IF / ID
//           o_wp, o_rp              current write / read slot
//           o_count                 occupied entries
//           o_full, o_valid         occupancy flags
//           o_wr_en                 storage write strobe for slot o_wp
import cpu_pkg::*;

module fq_ptr_ctrl #(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic          i_stall,
   input  logic          i_flush,
   input  logic          i_push,
   input  logic          i_pop,
   output logic [AW-1:0] o_wp,
   output logic [AW-1:0] o_rp,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_valid,
   output logic          o_wr_en
);

   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_count;

   logic w_full;
   logic w_valid;
   logic w_do_pop;
   logic w_do_push;
   logic w_advance;

   assign w_full   = (r_count == CW'(DEPTH));
   assign w_valid  = (r_count != '0);
   assign w_do_pop = i_pop & w_valid;
   // A pop in the same cycle frees the slot, so a full queue still takes the push.
   assign w_do_push = i_push & i_start & (~w_full | w_do_pop);
   // Push/pop only take effect when nothing higher in the chain claims the edge.
   assign w_advance = ~i_rst & ~i_stall & ~i_flush;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else if (i_stall) begin
         r_wp    <= r_wp;
         r_rp    <= r_rp;
         r_count <= r_count;
      end else if (i_flush) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wp <= r_wp + AW'(1);
         if (w_do_pop)  r_rp <= r_rp + AW'(1);
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   assign o_wp    = r_wp;
   assign o_rp    = r_rp;
   assign o_count = r_count;
   assign o_full  = w_full;
   assign o_valid = w_valid;
   assign o_wr_en = w_do_push & w_advance;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry {PC, instruction} queue at the IF/ID boundary
// Purpose : decouples instruction delivery from decode back-pressure while
//           keeping stall freeze, flush-to-NOP and start gating of the old latch.
// Ports   : clk_i, rst_i            clock, synchronous active-high reset
//           start_i                 run enable; low blocks pushes
//           stall_i                 global stall; freezes all state
//           flush_i                 branch flush; empties the queue
//           push_i, pc_i, inst_i    fetch side offer
//           full_o                  no free entry
//           pop_i                   decode consumes the head
//           valid_o, pc_o, inst_o   head entry (zeros / NOP when empty)
//           count_o                 occupied entries
import cpu_pkg::*;

module fetch_queue #(
   parameter int PC_W   = DEF_PC_W,
   parameter int INST_W = DEF_INST_W,
   parameter int DEPTH  = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic                       stall_i,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [PC_W-1:0]            pc_i,
   input  logic [INST_W-1:0]          inst_i,
   output logic                       full_o,
   input  logic                       pop_i,
   output logic                       valid_o,
   output logic [PC_W-1:0]            pc_o,
   output logic [INST_W-1:0]          inst_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   generate
      if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_depth_chk
         $error("fetch_queue: DEPTH must be a power of two and at least 2");
      end
   endgenerate

   logic [AW-1:0] w_wp;
   logic [AW-1:0] w_rp;
   logic [CW-1:0] w_count;
   logic          w_full;
   logic          w_valid;
   logic          w_wr_en;

   // Entry contents carry no reset; the valid gate on the outputs hides them.
   logic [PC_W-1:0]   r_pc_mem   [DEPTH];
   logic [INST_W-1:0] r_inst_mem [DEPTH];

   fq_ptr_ctrl #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .CW    (CW)
   ) u_ptr_ctrl (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_start (start_i),
      .i_stall (stall_i),
      .i_flush (flush_i),
      .i_push  (push_i),
      .i_pop   (pop_i),
      .o_wp    (w_wp),
      .o_rp    (w_rp),
      .o_count (w_count),
      .o_full  (w_full),
      .o_valid (w_valid),
      .o_wr_en (w_wr_en)
   );

   always_ff @(posedge clk_i) begin
      if (w_wr_en) begin
         r_pc_mem[w_wp]   <= pc_i;
         r_inst_mem[w_wp] <= inst_i;
      end
   end

   assign full_o  = w_full;
   assign valid_o = w_valid;
   assign count_o = w_count;
   assign pc_o    = w_valid ? r_pc_mem[w_rp]   : '0;
   assign inst_o  = w_valid ? r_inst_mem[w_rp] : INST_W'(NOP_INST);

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst, start, stall, flush, push, pop;
   logic [31:0] pc_in, inst_in;
   logic        full, valid;
   logic [31:0] pc_out, inst_out;
   logic [2:0]  count;

   int n_checks = 0;
   int n_errors = 0;

   fetch_queue #(.PC_W(32), .INST_W(32), .DEPTH(4)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .stall_i (stall),
      .flush_i (flush),
      .push_i  (push),
      .pc_i    (pc_in),
      .inst_i  (inst_in),
      .full_o  (full),
      .pop_i   (pop),
      .valid_o (valid),
      .pc_o    (pc_out),
      .inst_o  (inst_out),
      .count_o (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return 32'hA000_0000 | pc;
   endfunction

   task automatic set_push(input logic p, input logic [31:0] pc);
      push    = p;
      pc_in   = pc;
      inst_in = inst_of(pc);
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc, input logic [2:0] cnt);
      check({tag, "_valid"}, 64'(valid), 64'(1));
      check({tag, "_pc"},    64'(pc_out), 64'(pc));
      check({tag, "_inst"},  64'(inst_out), 64'(inst_of(pc)));
      check({tag, "_count"}, 64'(count), 64'(cnt));
   endtask

   task automatic check_empty(input string tag);
      check({tag, "_valid"}, 64'(valid), 64'(0));
      check({tag, "_pc"},    64'(pc_out), 64'(0));
      check({tag, "_inst"},  64'(inst_out), 64'(0));
      check({tag, "_count"}, 64'(count), 64'(0));
      check({tag, "_full"},  64'(full), 64'(0));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; pop = 1'b0;
      set_push(1'b0, 32'd0);
      step();
      step();
      rst = 1'b0;
      check_empty("reset");

      // start low blocks the push
      push = 1'b1; pc_in = 32'd100; inst_in = 32'h00A00093;
      step();
      check_empty("nostart");

      // fill to DEPTH
      start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_push(1'b1, 32'(4 * i));
         step();
         check_head($sformatf("fill%0d", i), 32'd0, 3'(i + 1));
      end
      check("fill_full", 64'(full), 64'(1));

      // push while full with no pop is dropped
      set_push(1'b1, 32'd16);
      step();
      check_head("overfill", 32'd0, 3'd4);

      // drain in order
      set_push(1'b0, 32'd0);
      pop = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_head($sformatf("drain%0d", i), 32'(4 * i), 3'(4 - i));
         step();
      end
      check_empty("drained");

      // pop when empty is ignored
      step();
      check_empty("pop_empty");
      pop = 1'b0;

      // refill, then push+pop while full
      for (int i = 0; i < 4; i++) begin
         set_push(1'b1, 32'(4 * i));
         step();
      end
      set_push(1'b1, 32'd16);
      pop = 1'b1;
      step();
      check_head("fullpp", 32'd4, 3'd4);
      check("fullpp_full", 64'(full), 64'(1));
      set_push(1'b0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         check_head($sformatf("wrap%0d", i), 32'(4 * i + 4), 3'(4 - i));
         step();
      end
      check_empty("wrap_done");
      pop = 1'b0;

      // flush with a same-cycle push
      set_push(1'b1, 32'd20); step();
      set_push(1'b1, 32'd24); step();
      check_head("preflush", 32'd20, 3'd2);
      set_push(1'b1, 32'd28);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_empty("flush");
      set_push(1'b1, 32'd32);
      step();
      check_head("postflush", 32'd32, 3'd1);
      set_push(1'b0, 32'd0);
      pop = 1'b1;
      step();
      pop = 1'b0;
      check_empty("postflush_pop");

      // stall freezes everything while other controls pulse
      for (int i = 0; i < 3; i++) begin
         set_push(1'b1, 32'(40 + 4 * i));
         step();
      end
      set_push(1'b0, 32'd0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         flush = (i == 0);
         if (i == 1) set_push(1'b1, 32'd52); else set_push(1'b0, 32'd0);
         pop   = (i == 2);
         step();
         check_head($sformatf("stall%0d", i), 32'd40, 3'd3);
      end
      stall = 1'b0; flush = 1'b0; pop = 1'b0;
      set_push(1'b0, 32'd0);
      step();
      check_head("unstall", 32'd40, 3'd3);

      // simultaneous push and pop when not full keeps count
      set_push(1'b1, 32'd56);
      pop = 1'b1;
      step();
      check_head("pp", 32'd44, 3'd3);
      set_push(1'b0, 32'd0);
      pop = 1'b0;

      // reset wins over stall
      rst = 1'b1; stall = 1'b1;
      step();
      rst = 1'b0; stall = 1'b0;
      check_empty("rst_stall");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
